m1553_word_rx: RTL and testbench
================================

Name: m1553_word_rx

Overview:
- MIL-STD-1553B Manchester II word receiver for one bus channel.
- Takes the transceiver's differential receive pair, detects the 3-bit-time sync, and decodes 16 data bits plus odd parity.
- Emits each word with a one-cycle valid strobe plus sync type and error flags.
- Sits directly upstream of the receive-word holding registers, which load on word_valid.

Parameters:
- CLKS_PER_BIT, 16, system clocks per 1 µs bit; must be even and at least 8. H = CLKS_PER_BIT/2 is the half-bit length.
- SYNC_TOL, 2, allowed deviation in clocks of each sync half from its nominal 3H length.

Ports:
- clk  in  1  system clock; everything is on the rising edge.
- rst  in  1  synchronous reset, active-high.
- rx_en  in  1  receiver enable; when low the FSM is forced to IDLE.
- rx_p  in  1  transceiver RX positive, asynchronous.
- rx_n  in  1  transceiver RX negative, asynchronous.
- word_o  out  16  decoded data bits; MSB is the first bit received.
- word_valid  out  1  one-cycle pulse; word_o and the flags are valid in that cycle.
- sync_cmd  out  1  1 = command/status sync (P then N); 0 = data sync (N then P).
- parity_err  out  1  odd-parity failure, qualified by word_valid.
- manch_err  out  1  at least one bit had no valid mid-bit transition, qualified by word_valid.
- sync_err  out  1  one-cycle pulse when a sync is aborted.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset:
  - rst=1 takes effect on the next edge.
  - All outputs go to 0, the FSM goes to IDLE and counters go to 0.
  - Reset mid-word discards the word; no word_valid is produced.
- Input path:
  - rx_p and rx_n each pass through a 2-flop synchronizer.
  - The synchronized pair is decoded to a line state: P = (1,0), N = (0,1), IDL = (0,0) or (1,1).
- Timing reference: t0 is the first cycle in which the synchronized line leaves IDL. The pins lead the synchronized line by 2 cycles.
- FSM states: IDLE, SYNC1, SYNC2, DATA, TAIL, ABORT.
- IDLE:
  - On a line state of P or N, latch that polarity as pol, set cnt=1 and go to SYNC1.
  - P gives sync_cmd=1; N gives sync_cmd=0.
- SYNC1:
  - cnt increments while the line equals pol.
  - On the opposite polarity with cnt in [3H-SYNC_TOL, 3H+SYNC_TOL], set cnt=1 and go to SYNC2.
  - On IDL, on the opposite polarity with cnt out of range, or when cnt exceeds 3H+SYNC_TOL, go to ABORT.
- SYNC2:
  - At cnt = 3H/2 the line must be the opposite of pol; otherwise go to ABORT.
  - At cnt = 3H, set bit=0, ph=0 and go to DATA. There is no edge resynchronisation.
- DATA:
  - ph counts 0..2H-1.
  - Sample the first half at ph = H/2 and the second half at ph = H+H/2.
  - P then N decodes as 1; N then P decodes as 0. Any other pair sets the sticky manch_flag and the bit shifts in as 0.
  - At ph = 2H-1, ph wraps and bit increments.
  - Bits 0..15 shift into the data register; bit 16 is the parity bit.
  - On the bit-16 second-half sample, go to TAIL and register the outputs.
- Word output:
  - word_valid is high in the cycle after the bit-16 second-half sample, i.e. t0 + 6H + 32H + H + H/2 + 1 (cycle t0+317 for H=8).
  - In that cycle: word_o = data; parity_err = ~(^data ^ parity); manch_err = manch_flag.
  - Errors do not suppress word_valid.
  - word_o holds until the next word. The flags are meaningful only with word_valid.
- TAIL: wait until ph = 2H-1 (the end of the parity bit), then go to IDLE. This allows back-to-back words with no gap.
- ABORT:
  - Pulse sync_err for 1 cycle on entry.
  - Stay in ABORT until the line is IDL, then go to IDLE.
- rx_en:
  - rx_en=0 in any state forces IDLE next cycle and discards any partial word silently, with no sync_err.
  - rx_en=1 mid-word takes effect only from IDLE.
- Counter width: cnt and ph are wide enough for 3H+SYNC_TOL+1.

Decomposition:
- Package m1553_pkg holds:
  - line-state encoding (IDL/P/N);
  - FSM state enum;
  - constant WORD_BITS=16;
  - sync-type encoding.
- One sub-module, m1553_rx_sync: the 2-flop synchronizer plus line-state decode.
- All shift, count and FSM logic stays in m1553_word_rx.

Test Plan (CLKS_PER_BIT=16, SYNC_TOL=2):
1. Command sync followed by 0x1234 with parity 0 (0x1234 has 5 ones) → word_valid 1 cycle at t0+317, word_o=0x1234, sync_cmd=1, parity_err=0, manch_err=0.
2. Data sync followed by 0xFFFF with parity 0 (even total) → word_o=0xFFFF, sync_cmd=0, parity_err=1.
3. Two back-to-back words, command 0xA5A5 then data 0x0001, no gap → two word_valid pulses exactly 320 cycles apart with correct sync_cmd each.
4. Bit 5 held at P for the full bit (no mid-bit transition) → word_valid with manch_err=1.
5. First sync half of 20 cycles (lengths 22..26 accepted) → sync_err pulse, no word_valid, busy returns 0 after the line goes idle.
6. rst=1 at cycle t0+150 → all outputs 0 next cycle, no word_valid. A following clean 0x1234 word decodes correctly.

Source files
------------

// File: rtl/m1553_pkg.sv
// rtl/m1553_pkg.sv - shared encodings for the 1553 word receiver
package m1553_pkg;

  localparam int WORD_BITS = 16;

  // Line state seen on the synchronized differential pair
  typedef enum logic [1:0] {
    LINE_IDL = 2'b00,
    LINE_P   = 2'b01,
    LINE_N   = 2'b10
  } line_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC1,
    ST_SYNC2,
    ST_DATA,
    ST_TAIL,
    ST_ABORT
  } state_t;

  // Sync type: command/status sync starts positive, data sync starts negative
  localparam logic SYNC_TYPE_CMD  = 1'b1;
  localparam logic SYNC_TYPE_DATA = 1'b0;

  // Both legs equal (00 or 11) carries no information and counts as idle
  function automatic line_t decode_line(input logic p, input logic n);
    if (p && !n) begin
      return LINE_P;
    end else if (!p && n) begin
      return LINE_N;
    end else begin
      return LINE_IDL;
    end
  endfunction

endpackage

// File: rtl/m1553_rx_sync.sv
// rtl/m1553_rx_sync.sv - input synchronizer and line-state decode
module m1553_rx_sync
  import m1553_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_p,
  input  logic       rx_n,
  output logic [1:0] line
);

  logic [1:0] p_sync;
  logic [1:0] n_sync;

  // Two-flop synchronizer per leg; the pins lead the decoded line by two cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      p_sync <= '0;
      n_sync <= '0;
    end else begin
      p_sync <= {p_sync[0], rx_p};
      n_sync <= {n_sync[0], rx_n};
    end
  end

  assign line = decode_line(p_sync[1], n_sync[1]);

endmodule

// File: rtl/m1553_word_rx.sv
// rtl/m1553_word_rx.sv - Manchester II word receiver with sync detect
module m1553_word_rx
  import m1553_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int SYNC_TOL     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_en,
  input  logic        rx_p,
  input  logic        rx_n,
  output logic [15:0] word_o,
  output logic        word_valid,
  output logic        sync_cmd,
  output logic        parity_err,
  output logic        manch_err,
  output logic        sync_err,
  output logic        busy
);

  localparam int H        = CLKS_PER_BIT / 2;
  localparam int SYNC_NOM = 3 * H;
  localparam int CW       = $clog2(SYNC_NOM + SYNC_TOL + 2);
  localparam int BW       = $clog2(WORD_BITS + 1);

  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MIN = CW'(SYNC_NOM - SYNC_TOL);
  localparam logic [CW-1:0] CNT_MAX = CW'(SYNC_NOM + SYNC_TOL);
  localparam logic [CW-1:0] CNT_MID = CW'(SYNC_NOM / 2);
  // cnt reaching 3H on this edge means the next cycle is the first of bit 0
  localparam logic [CW-1:0] CNT_END = CW'(SYNC_NOM - 1);
  localparam logic [CW-1:0] PH_H1   = CW'(H / 2);
  localparam logic [CW-1:0] PH_H2   = CW'(H + H / 2);
  localparam logic [CW-1:0] PH_LAST = CW'(2 * H - 1);
  localparam logic [BW-1:0] BIT_PAR = BW'(WORD_BITS);

  logic [1:0]           line;
  state_t               state, state_nxt;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic [CW-1:0]        ph, ph_nxt;
  logic [BW-1:0]        bit_idx, bit_nxt;
  logic [1:0]           pol, pol_nxt;
  logic [1:0]           half1, half1_nxt;
  logic [WORD_BITS-1:0] data, data_nxt;
  logic                 manch_flag, manch_nxt;
  logic [15:0]          word_nxt;
  logic                 valid_nxt, cmd_nxt, perr_nxt, merr_nxt, serr_nxt;
  logic [1:0]           opp;
  logic                 bit_ok, bit_val;

  m1553_rx_sync u_sync (
    .clk  (clk),
    .rst  (rst),
    .rx_p (rx_p),
    .rx_n (rx_n),
    .line (line)
  );

  assign opp     = (pol == LINE_P) ? LINE_N : LINE_P;
  assign bit_ok  = ((half1 == LINE_P) && (line == LINE_N)) ||
                   ((half1 == LINE_N) && (line == LINE_P));
  assign bit_val = (half1 == LINE_P) && (line == LINE_N);
  assign busy    = (state != ST_IDLE);

  // Next-state, counters, shift register and output strobes
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ph_nxt    = ph;
    bit_nxt   = bit_idx;
    pol_nxt   = pol;
    half1_nxt = half1;
    data_nxt  = data;
    manch_nxt = manch_flag;
    word_nxt  = word_o;
    valid_nxt = 1'b0;
    cmd_nxt   = sync_cmd;
    perr_nxt  = parity_err;
    merr_nxt  = manch_err;
    serr_nxt  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (line != LINE_IDL) begin
          pol_nxt   = line;
          cmd_nxt   = (line == LINE_P) ? SYNC_TYPE_CMD : SYNC_TYPE_DATA;
          cnt_nxt   = CNT_ONE;
          state_nxt = ST_SYNC1;
        end
      end
      ST_SYNC1: begin
        if (line == pol) begin
          if (cnt >= CNT_MAX) begin
            state_nxt = ST_ABORT;
            serr_nxt  = 1'b1;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end else if ((line == opp) && (cnt >= CNT_MIN) && (cnt <= CNT_MAX)) begin
          cnt_nxt   = CNT_ONE;
          state_nxt = ST_SYNC2;
        end else begin
          state_nxt = ST_ABORT;
          serr_nxt  = 1'b1;
        end
      end
      ST_SYNC2: begin
        cnt_nxt = cnt + 1'b1;
        if ((cnt == CNT_MID) && (line != opp)) begin
          state_nxt = ST_ABORT;
          serr_nxt  = 1'b1;
        end else if (cnt == CNT_END) begin
          ph_nxt    = '0;
          bit_nxt   = '0;
          manch_nxt = 1'b0;
          state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (ph == PH_LAST) begin
          ph_nxt  = '0;
          bit_nxt = bit_idx + 1'b1;
        end else begin
          ph_nxt = ph + 1'b1;
        end
        if (ph == PH_H1) begin
          half1_nxt = line;
        end
        if (ph == PH_H2) begin
          if (!bit_ok) begin
            manch_nxt = 1'b1;
          end
          if (bit_idx < BIT_PAR) begin
            data_nxt = {data[WORD_BITS-2:0], bit_val};
          end else begin
            word_nxt  = data;
            valid_nxt = 1'b1;
            perr_nxt  = ~(^data ^ bit_val);
            merr_nxt  = manch_flag | ~bit_ok;
            state_nxt = ST_TAIL;
          end
        end
      end
      ST_TAIL: begin
        ph_nxt = ph + 1'b1;
        if (ph == PH_LAST) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_ABORT: begin
        if (line == LINE_IDL) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    // Disabling the receiver drops any partial word without reporting it
    if (!rx_en) begin
      state_nxt = ST_IDLE;
      valid_nxt = 1'b0;
      serr_nxt  = 1'b0;
      word_nxt  = word_o;
      perr_nxt  = parity_err;
      merr_nxt  = manch_err;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      ph         <= '0;
      bit_idx    <= '0;
      pol        <= LINE_IDL;
      half1      <= LINE_IDL;
      data       <= '0;
      manch_flag <= 1'b0;
      word_o     <= '0;
      word_valid <= 1'b0;
      sync_cmd   <= 1'b0;
      parity_err <= 1'b0;
      manch_err  <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      ph         <= ph_nxt;
      bit_idx    <= bit_nxt;
      pol        <= pol_nxt;
      half1      <= half1_nxt;
      data       <= data_nxt;
      manch_flag <= manch_nxt;
      word_o     <= word_nxt;
      word_valid <= valid_nxt;
      sync_cmd   <= cmd_nxt;
      parity_err <= perr_nxt;
      manch_err  <= merr_nxt;
      sync_err   <= serr_nxt;
    end
  end

endmodule

// File: tb/tb_m1553_word_rx.sv
// tb/tb_m1553_word_rx.sv - directed self-checking bench for m1553_word_rx
module tb_m1553_word_rx;

  localparam logic [1:0] LP = 2'b10;
  localparam logic [1:0] LN = 2'b01;
  localparam logic [1:0] LI = 2'b00;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_en = 1'b1;
  logic        rx_p = 1'b0;
  logic        rx_n = 1'b0;
  logic [15:0] word_o;
  logic        word_valid, sync_cmd, parity_err, manch_err, sync_err, busy;

  int pc = 0;
  int checks = 0;
  int errors = 0;
  int start = 0;

  logic [1:0]  q[$];
  int          v_pc[$];
  logic [15:0] v_word[$];
  logic        v_cmd[$];
  logic        v_perr[$];
  logic        v_merr[$];
  int          se_pc[$];

  m1553_word_rx #(.CLKS_PER_BIT(16), .SYNC_TOL(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_en      (rx_en),
    .rx_p       (rx_p),
    .rx_n       (rx_n),
    .word_o     (word_o),
    .word_valid (word_valid),
    .sync_cmd   (sync_cmd),
    .parity_err (parity_err),
    .manch_err  (manch_err),
    .sync_err   (sync_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) pc <= pc + 1;

  always @(negedge clk) begin
    if (word_valid === 1'b1) begin
      v_pc.push_back(pc);
      v_word.push_back(word_o);
      v_cmd.push_back(sync_cmd);
      v_perr.push_back(parity_err);
      v_merr.push_back(manch_err);
    end
    if (sync_err === 1'b1) se_pc.push_back(pc);
  end

  task automatic clear_log();
    v_pc.delete(); v_word.delete(); v_cmd.delete();
    v_perr.delete(); v_merr.delete(); se_pc.delete();
  endtask

  task automatic add_half(input logic [1:0] s, input int n);
    for (int i = 0; i < n; i++) q.push_back(s);
  endtask

  task automatic add_word(input logic cmd, input logic [15:0] d, input logic par,
                          input int bad, input int len1);
    logic b;
    add_half(cmd ? LP : LN, len1);
    add_half(cmd ? LN : LP, 24);
    for (int i = 0; i < 17; i++) begin
      b = (i < 16) ? d[15-i] : par;
      if (i == bad) begin
        add_half(LP, 16);
      end else if (b) begin
        add_half(LP, 8); add_half(LN, 8);
      end else begin
        add_half(LN, 8); add_half(LP, 8);
      end
    end
  endtask

  task automatic play();
    for (int k = 0; k < q.size(); k++) begin
      rx_p = q[k][1];
      rx_n = q[k][0];
      @(negedge clk);
    end
    rx_p = 1'b0;
    rx_n = 1'b0;
    q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_en = 1'b1; rx_p = 1'b0; rx_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (word_o !== 16'h0) begin errors++; $display("FAIL reset_word_o: got %h expected 0000", word_o); end
    checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL reset_word_valid: got %b expected 0", word_valid); end
    checks++; if (sync_cmd !== 1'b0) begin errors++; $display("FAIL reset_sync_cmd: got %b expected 0", sync_cmd); end
    checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL reset_parity_err: got %b expected 0", parity_err); end
    checks++; if (manch_err !== 1'b0) begin errors++; $display("FAIL reset_manch_err: got %b expected 0", manch_err); end
    checks++; if (sync_err !== 1'b0) begin errors++; $display("FAIL reset_sync_err: got %b expected 0", sync_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_cmd_word();
    clear_log();
    add_word(1'b1, 16'h1234, 1'b0, -1, 24);
    add_half(LI, 40);
    start = pc;
    play();
    checks++; if (v_pc.size() != 1) begin errors++; $display("FAIL cmd_valid_count: got %0d expected 1", v_pc.size()); end
    if (v_pc.size() == 1) begin
      checks++; if (v_pc[0] != start + 319) begin errors++; $display("FAIL cmd_valid_cycle: got %0d expected %0d", v_pc[0] - start, 319); end
      checks++; if (v_word[0] !== 16'h1234) begin errors++; $display("FAIL cmd_word_o: got %h expected 1234", v_word[0]); end
      checks++; if (v_cmd[0] !== 1'b1) begin errors++; $display("FAIL cmd_sync_cmd: got %b expected 1", v_cmd[0]); end
      checks++; if (v_perr[0] !== 1'b0) begin errors++; $display("FAIL cmd_parity_err: got %b expected 0", v_perr[0]); end
      checks++; if (v_merr[0] !== 1'b0) begin errors++; $display("FAIL cmd_manch_err: got %b expected 0", v_merr[0]); end
    end
    checks++; if (se_pc.size() != 0) begin errors++; $display("FAIL cmd_sync_err_count: got %0d expected 0", se_pc.size()); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cmd_busy_end: got %b expected 0", busy); end
  endtask

  task automatic test_data_word();
    clear_log();
    add_word(1'b0, 16'hFFFF, 1'b0, -1, 24);
    add_half(LI, 40);
    start = pc;
    play();
    checks++; if (v_pc.size() != 1) begin errors++; $display("FAIL data_valid_count: got %0d expected 1", v_pc.size()); end
    if (v_pc.size() == 1) begin
      checks++; if (v_word[0] !== 16'hFFFF) begin errors++; $display("FAIL data_word_o: got %h expected ffff", v_word[0]); end
      checks++; if (v_cmd[0] !== 1'b0) begin errors++; $display("FAIL data_sync_cmd: got %b expected 0", v_cmd[0]); end
      checks++; if (v_perr[0] !== 1'b1) begin errors++; $display("FAIL data_parity_err: got %b expected 1", v_perr[0]); end
      checks++; if (v_merr[0] !== 1'b0) begin errors++; $display("FAIL data_manch_err: got %b expected 0", v_merr[0]); end
    end
  endtask

  task automatic test_back_to_back();
    clear_log();
    add_word(1'b1, 16'hA5A5, 1'b1, -1, 24);
    add_word(1'b0, 16'h0001, 1'b0, -1, 24);
    add_half(LI, 40);
    start = pc;
    play();
    checks++; if (v_pc.size() != 2) begin errors++; $display("FAIL b2b_valid_count: got %0d expected 2", v_pc.size()); end
    if (v_pc.size() == 2) begin
      checks++; if (v_pc[0] != start + 319) begin errors++; $display("FAIL b2b_first_cycle: got %0d expected 319", v_pc[0] - start); end
      checks++; if (v_pc[1] - v_pc[0] != 320) begin errors++; $display("FAIL b2b_spacing: got %0d expected 320", v_pc[1] - v_pc[0]); end
      checks++; if (v_word[0] !== 16'hA5A5) begin errors++; $display("FAIL b2b_word0: got %h expected a5a5", v_word[0]); end
      checks++; if (v_word[1] !== 16'h0001) begin errors++; $display("FAIL b2b_word1: got %h expected 0001", v_word[1]); end
      checks++; if (v_cmd[0] !== 1'b1) begin errors++; $display("FAIL b2b_cmd0: got %b expected 1", v_cmd[0]); end
      checks++; if (v_cmd[1] !== 1'b0) begin errors++; $display("FAIL b2b_cmd1: got %b expected 0", v_cmd[1]); end
      checks++; if (v_perr[0] !== 1'b0) begin errors++; $display("FAIL b2b_perr0: got %b expected 0", v_perr[0]); end
      checks++; if (v_perr[1] !== 1'b0) begin errors++; $display("FAIL b2b_perr1: got %b expected 0", v_perr[1]); end
    end
  endtask

  task automatic test_manchester();
    clear_log();
    add_word(1'b1, 16'h1234, 1'b0, 5, 24);
    add_half(LI, 40);
    start = pc;
    play();
    checks++; if (v_pc.size() != 1) begin errors++; $display("FAIL manch_valid_count: got %0d expected 1", v_pc.size()); end
    if (v_pc.size() == 1) begin
      checks++; if (v_merr[0] !== 1'b1) begin errors++; $display("FAIL manch_err_flag: got %b expected 1", v_merr[0]); end
      checks++; if (v_word[0] !== 16'h1234) begin errors++; $display("FAIL manch_word_o: got %h expected 1234", v_word[0]); end
      checks++; if (v_perr[0] !== 1'b0) begin errors++; $display("FAIL manch_parity_err: got %b expected 0", v_perr[0]); end
    end
  endtask

  task automatic test_sync_tol();
    int   lens[5]   = '{20, 21, 22, 26, 27};
    logic acc[5]    = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    int   se_cyc[5] = '{23, 24, 0, 0, 0};
    int   vcyc[5]   = '{0, 0, 317, 321, 0};
    for (int t = 0; t < 5; t++) begin
      clear_log();
      add_word(1'b1, 16'h1234, 1'b0, -1, lens[t]);
      add_half(LI, 40);
      start = pc;
      play();
      if (acc[t]) begin
        checks++; if (v_pc.size() != 1) begin errors++; $display("FAIL tol_valid_count len=%0d: got %0d expected 1", lens[t], v_pc.size()); end
        if (v_pc.size() == 1) begin
          checks++; if (v_pc[0] != start + vcyc[t]) begin errors++; $display("FAIL tol_valid_cycle len=%0d: got %0d expected %0d", lens[t], v_pc[0] - start, vcyc[t]); end
        end
        checks++; if (se_pc.size() != 0) begin errors++; $display("FAIL tol_sync_err len=%0d: got %0d pulses expected 0", lens[t], se_pc.size()); end
      end else begin
        checks++; if (v_pc.size() != 0) begin errors++; $display("FAIL tol_no_valid len=%0d: got %0d expected 0", lens[t], v_pc.size()); end
        checks++; if (se_pc.size() != 1) begin errors++; $display("FAIL tol_sync_err len=%0d: got %0d pulses expected 1", lens[t], se_pc.size()); end
        if ((se_pc.size() == 1) && (se_cyc[t] != 0)) begin
          checks++; if (se_pc[0] != start + se_cyc[t]) begin errors++; $display("FAIL tol_sync_err_cycle len=%0d: got %0d expected %0d", lens[t], se_pc[0] - start, se_cyc[t]); end
        end
      end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tol_busy_end len=%0d: got %b expected 0", lens[t], busy); end
    end
  endtask

  task automatic test_rx_en();
    clear_log();
    add_word(1'b1, 16'h5555, 1'b1, -1, 24);
    add_half(LI, 40);
    start = pc;
    fork
      play();
      begin
        repeat (100) @(negedge clk);
        rx_en = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rxen_busy: got %b expected 0", busy); end
        checks++; if (sync_err !== 1'b0) begin errors++; $display("FAIL rxen_sync_err: got %b expected 0", sync_err); end
        rx_en = 1'b1;
      end
    join
    checks++; if (v_pc.size() != 0) begin errors++; $display("FAIL rxen_no_valid: got %0d expected 0", v_pc.size()); end
  endtask

  task automatic test_reset_mid();
    clear_log();
    add_word(1'b1, 16'h1234, 1'b0, -1, 24);
    add_half(LI, 30);
    add_word(1'b1, 16'h1234, 1'b0, -1, 24);
    add_half(LI, 40);
    start = pc;
    fork
      play();
      begin
        repeat (152) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (word_o !== 16'h0) begin errors++; $display("FAIL rstmid_word_o: got %h expected 0000", word_o); end
        checks++; if (sync_cmd !== 1'b0) begin errors++; $display("FAIL rstmid_sync_cmd: got %b expected 0", sync_cmd); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
        checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL rstmid_word_valid: got %b expected 0", word_valid); end
        rst = 1'b0;
      end
    join
    checks++; if (v_pc.size() != 1) begin errors++; $display("FAIL rstmid_valid_count: got %0d expected 1", v_pc.size()); end
    if (v_pc.size() == 1) begin
      checks++; if (v_pc[0] != start + 669) begin errors++; $display("FAIL rstmid_valid_cycle: got %0d expected 669", v_pc[0] - start); end
      checks++; if (v_word[0] !== 16'h1234) begin errors++; $display("FAIL rstmid_word: got %h expected 1234", v_word[0]); end
      checks++; if (v_perr[0] !== 1'b0) begin errors++; $display("FAIL rstmid_parity_err: got %b expected 0", v_perr[0]); end
    end
  endtask

  initial begin
    test_reset();
    test_cmd_word();
    test_data_word();
    test_back_to_back();
    test_manchester();
    test_sync_tol();
    test_rx_en();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
